// File: rtl/alu_writeback_stage.sv
// In-order result queue between the ALU and the register-file write port.
// Retires entries to the register file and the {N,Z,C,V} flags, and answers operand bypass queries.
module alu_writeback_stage #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_we_reg,
  input  logic              in_we_flags,
  input  logic              in_carry,
  input  logic              in_ovf,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic [3:0]        flags_q,
  input  logic [RA_W-1:0]   fwd_rd,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] ent_res_q [DEPTH];
  logic [RA_W-1:0]   ent_rd_q  [DEPTH];
  logic              ent_wer_q [DEPTH];
  logic              ent_wef_q [DEPTH];
  logic              ent_c_q   [DEPTH];
  logic              ent_v_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    flags_d;

  logic accept, retire, head_valid, head_wer;

  assign in_ready   = !rst && (count_q < FULL);
  assign accept     = in_valid && in_ready;
  assign head_valid = (count_q != '0);
  assign head_wer   = ent_wer_q[rd_ptr_q];
  // Register writes wait for the port; flags-only entries never stall.
  assign retire     = head_valid && (!head_wer || rf_ready);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (retire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (ent_wef_q[rd_ptr_q]) begin
        flags_d = {ent_res_q[rd_ptr_q][DATA_W-1], (ent_res_q[rd_ptr_q] == '0),
                   ent_c_q[rd_ptr_q], ent_v_q[rd_ptr_q]};
      end
    end
    count_d = count_q + CW'(accept) - CW'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= 4'b0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ent_res_q[wr_ptr_q] <= in_result;
      ent_rd_q[wr_ptr_q]  <= in_rd;
      ent_wer_q[wr_ptr_q] <= in_we_reg;
      ent_wef_q[wr_ptr_q] <= in_we_flags;
      ent_c_q[wr_ptr_q]   <= in_carry;
      ent_v_q[wr_ptr_q]   <= in_ovf;
    end
  end

  assign rf_we    = !rst && head_valid && head_wer;
  assign rf_waddr = rf_we ? ent_rd_q[rd_ptr_q]  : '0;
  assign rf_wdata = rf_we ? ent_res_q[rd_ptr_q] : '0;
  assign busy     = !rst && head_valid;

  // Matches indexed by age (0 = head), so the last hit in the scan is the youngest.
  logic              age_match [DEPTH];
  logic [DATA_W-1:0] age_data  [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PW-1:0] slot;
      assign slot          = rd_ptr_q + PW'(gi);
      assign age_match[gi] = (CW'(gi) < count_q) && ent_wer_q[slot] && (ent_rd_q[slot] == fwd_rd);
      assign age_data[gi]  = ent_res_q[slot];
    end
  endgenerate

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_match[i]) begin
          fwd_hit  = 1'b1;
          fwd_data = age_data[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Randomised bench for alu_writeback_stage: queue-level reference model plus a write scoreboard.
module tb_alu_writeback_stage;

  localparam int DATA_W = 8;
  localparam int RA_W   = 3;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [RA_W-1:0]   in_rd;
  logic              in_we_reg;
  logic              in_we_flags;
  logic              in_carry;
  logic              in_ovf;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;
  logic [3:0]        flags_q;
  logic [RA_W-1:0]   fwd_rd;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              busy;

  alu_writeback_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_rd(in_rd),
    .in_we_reg(in_we_reg), .in_we_flags(in_we_flags), .in_carry(in_carry), .in_ovf(in_ovf),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags_q(flags_q), .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [2:0] rd;
    logic       wer;
    logic       wef;
    logic       c;
    logic       v;
  } ent_t;

  typedef struct {
    logic [2:0] rd;
    logic [7:0] d;
  } wr_t;

  ent_t       pend[$];     // results the stage should still be holding, oldest first
  wr_t        exp_wr[$];   // register writes expected, in order
  logic [3:0] m_flags = 4'b0000;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model at the edge.
  task automatic step(input logic v, input ent_t e, input logic rfr, input logic [2:0] frd,
                      output logic acc);
    logic       m_ready, m_rfwe, m_hit, m_ret, m_busy;
    logic [2:0] m_wa;
    logic [7:0] m_wd, m_fd;
    in_valid = v; in_result = e.res; in_rd = e.rd; in_we_reg = e.wer;
    in_we_flags = e.wef; in_carry = e.c; in_ovf = e.v; rf_ready = rfr; fwd_rd = frd;
    #1;
    m_ready = !rst && (pend.size() < DEPTH);
    m_busy  = !rst && (pend.size() != 0);
    m_rfwe  = m_busy && pend[0].wer;
    m_wa    = m_rfwe ? pend[0].rd : 3'd0;
    m_wd    = m_rfwe ? pend[0].res : 8'd0;
    m_hit   = 1'b0;
    m_fd    = 8'd0;
    if (!rst) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].wer && pend[i].rd == frd) begin
          m_hit = 1'b1;
          m_fd  = pend[i].res;
          break;
        end
      end
    end
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rf_we", 32'(rf_we), 32'(m_rfwe));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_wa));
    chk("rf_wdata", 32'(rf_wdata), 32'(m_wd));
    chk("fwd_hit", 32'(fwd_hit), 32'(m_hit));
    chk("fwd_data", 32'(fwd_data), 32'(m_fd));
    chk("flags", 32'(flags_q), 32'(m_flags));
    acc   = v && m_ready;
    m_ret = m_busy && (!pend[0].wer || rfr);
    if (acc && e.wer) exp_wr.push_back('{rd: e.rd, d: e.res});
    @(posedge clk);
    if (rst) begin
      pend.delete();
      exp_wr.delete();
      m_flags = 4'b0000;
    end else begin
      if (m_ret) begin
        if (pend[0].wef) m_flags = {pend[0].res[7], pend[0].res == 8'd0, pend[0].c, pend[0].v};
        void'(pend.pop_front());
      end
      if (acc) pend.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.res = 8'($urandom);
    e.rd  = 3'($urandom_range(0, 7));
    e.wer = 1'($urandom);
    e.wef = 1'($urandom);
    e.c   = 1'($urandom);
    e.v   = 1'($urandom);
    return e;
  endfunction

  function automatic logic rf_mode(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return cyc[0];
      default: return 1'($urandom);
    endcase
  endfunction

  // Hold a result on the input until it is accepted (bounded).
  task automatic push(input ent_t e, input int mode);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) step(1'b1, e, rf_mode(mode), e.rd, acc);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic idle(input int n, input int mode);
    logic acc;
    ent_t z;
    z = '{res: 8'd0, rd: 3'd0, wer: 1'b0, wef: 1'b0, c: 1'b0, v: 1'b0};
    for (int k = 0; k < n; k++) step(1'b0, z, rf_mode(mode), 3'($urandom_range(0, 7)), acc);
  endtask

  // Scoreboard monitor: every accepted register write must match the next expected one.
  initial begin : monitor
    wr_t w;
    forever begin
      @(negedge clk);
      #2;
      if (rf_we === 1'b1 && rf_ready === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", rf_waddr, rf_wdata);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(rf_waddr), 32'(w.rd));
          chk("wr_data", 32'(rf_wdata), 32'(w.d));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic acc;
    ent_t e;
    rst = 1'b1;
    in_valid = 1'b0; in_result = '0; in_rd = '0; in_we_reg = 1'b0; in_we_flags = 1'b0;
    in_carry = 1'b0; in_ovf = 1'b0; rf_ready = 1'b0; fwd_rd = '0;
    @(negedge clk);
    idle(1, 0);
    rst = 1'b0;
    idle(1, 1);

    // Single shift result: 0x80 >>> 3 = 0xF0 to r5 with flags.
    push('{res: 8'hF0, rd: 3'd5, wer: 1'b1, wef: 1'b1, c: 1'b0, v: 1'b0}, 1);
    chk("shift_rf_we", 32'(rf_we), 32'd1);
    idle(1, 1);
    chk("shift_flags", 32'(flags_q), 32'h8);

    // Flags-only zero result retires even with the port stalled.
    push('{res: 8'h00, rd: 3'd0, wer: 1'b0, wef: 1'b1, c: 1'b1, v: 1'b0}, 0);
    idle(1, 0);
    chk("zero_flags", 32'(flags_q), 32'h6);

    // Back-pressure: two pending writes fill the queue, the third waits.
    push('{res: 8'h11, rd: 3'd1, wer: 1'b1, wef: 1'b0, c: 1'b0, v: 1'b0}, 0);
    push('{res: 8'h22, rd: 3'd2, wer: 1'b1, wef: 1'b0, c: 1'b0, v: 1'b0}, 0);
    e = '{res: 8'h33, rd: 3'd3, wer: 1'b1, wef: 1'b1, c: 1'b0, v: 1'b1};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, e, 1'b0, 3'd1, acc);
      chk("full_hold", 32'(acc), 32'd0);
    end
    push(e, 1);
    idle(3, 1);

    // Bypass picks the younger of two entries targeting r3.
    push('{res: 8'h0A, rd: 3'd3, wer: 1'b1, wef: 1'b0, c: 1'b0, v: 1'b0}, 0);
    push('{res: 8'h0B, rd: 3'd3, wer: 1'b1, wef: 1'b0, c: 1'b0, v: 1'b0}, 0);
    step(1'b0, e, 1'b0, 3'd3, acc);
    step(1'b0, e, 1'b0, 3'd4, acc);
    in_valid = 1'b0; fwd_rd = 3'd3; rf_ready = 1'b0;
    #1;
    chk("bypass_young", 32'(fwd_data), 32'h0B);
    @(negedge clk);
    idle(3, 1);

    // Ten back-to-back results across pointer wrap, rf_ready toggling.
    for (int k = 0; k < 10; k++) begin
      e = rnd_ent();
      e.wer = 1'b1;
      push(e, 2);
    end
    idle(4, 1);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom), rnd_ent(), 1'($urandom), 3'($urandom_range(0, 7)), acc);
    end
    idle(4, 1);

    // Reset with two pending writes discards them.
    push('{res: 8'h5A, rd: 3'd6, wer: 1'b1, wef: 1'b1, c: 1'b1, v: 1'b1}, 0);
    push('{res: 8'hA5, rd: 3'd7, wer: 1'b1, wef: 1'b1, c: 1'b0, v: 1'b0}, 0);
    rst = 1'b1;
    idle(1, 1);
    rst = 1'b0;
    idle(1, 1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    idle(2, 1);

    chk("scoreboard_empty", 32'(exp_wr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
